// File: rtl/mac_vector_feeder_if.sv
// Channel bundle between the MAC vector feeder and its neighbours: upstream operand
// pairs, the three MAC operand channels, the MAC result return, the final result and FIFO level.
interface mac_vector_feeder_if #(
    parameter int AW = 3
);
    logic [31:0] input_a;
    logic [31:0] input_b;
    logic        input_last;
    logic        input_stb;
    logic        input_ack;

    logic [31:0] output_a;
    logic        output_a_stb;
    logic        output_a_ack;
    logic [31:0] output_b;
    logic        output_b_stb;
    logic        output_b_ack;
    logic [31:0] output_c;
    logic        output_c_stb;
    logic        output_c_ack;

    logic [31:0] mac_z;
    logic        mac_z_stb;
    logic        mac_z_ack;

    logic [31:0] result_z;
    logic        result_z_stb;
    logic        result_z_ack;

    logic [AW:0] fifo_level;

    // master is the feeder itself; slave is everything around it (upstream, MAC, sink)
    modport master (
        input  input_a, input_b, input_last, input_stb,
        output input_ack,
        output output_a, output_a_stb, output_b, output_b_stb, output_c, output_c_stb,
        input  output_a_ack, output_b_ack, output_c_ack,
        input  mac_z, mac_z_stb,
        output mac_z_ack,
        output result_z, result_z_stb,
        input  result_z_ack,
        output fifo_level
    );

    modport slave (
        output input_a, input_b, input_last, input_stb,
        input  input_ack,
        input  output_a, output_a_stb, output_b, output_b_stb, output_c, output_c_stb,
        output output_a_ack, output_b_ack, output_c_ack,
        output mac_z, mac_z_stb,
        input  mac_z_ack,
        input  result_z, result_z_stb,
        output result_z_ack,
        input  fifo_level
    );
endinterface

// File: rtl/mac_vector_feeder.sv
// Operand sequencer for a float32 MAC: queues (a, b, last) pairs, issues them with the
// running accumulator as c, and emits the final MAC result of each tagged vector.
module mac_vector_feeder #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic                clk,
    input  logic                rst,
    mac_vector_feeder_if.master feeder_if
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_Z, RESULT} state_e;

    typedef struct packed {
        logic        last;
        logic [31:0] a;
        logic [31:0] b;
    } entry_t;

    localparam logic [AW:0] FULL_LEVEL = DEPTH[AW:0];

    entry_t        mem_q [DEPTH];
    entry_t        head;
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   level_q;
    logic [AW:0]   level_d;
    logic          wr_en;
    logic          rd_en;

    state_e        state_q;
    logic [31:0]   a_q;
    logic [31:0]   b_q;
    logic [31:0]   c_q;
    logic [31:0]   acc_q;
    logic [31:0]   result_q;
    logic          last_q;
    logic          a_stb_q;
    logic          b_stb_q;
    logic          c_stb_q;
    logic          z_ack_q;
    logic          result_stb_q;
    logic          a_stb_d;
    logic          b_stb_d;
    logic          c_stb_d;

    assign feeder_if.input_ack = (level_q != FULL_LEVEL);
    assign wr_en = feeder_if.input_stb && feeder_if.input_ack;
    assign rd_en = (state_q == IDLE) && (level_q != '0);
    assign head  = mem_q[rd_ptr_q];

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        level_d = level_q;
        if (wr_en && !rd_en) begin
            level_d = level_q + 1'b1;
        end else if (rd_en && !wr_en) begin
            level_d = level_q - 1'b1;
        end
    end

    // NOTE: the storage array has no reset; pointers and level alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= '{last: feeder_if.input_last, a: feeder_if.input_a, b: feeder_if.input_b};
        end
    end

    // Pointers are exactly AW bits wide, so increments wrap modulo DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
        end
    end

    // Each operand strobe retires on its own transfer; the issue completes when all have retired.
    assign a_stb_d = a_stb_q && !feeder_if.output_a_ack;
    assign b_stb_d = b_stb_q && !feeder_if.output_b_ack;
    assign c_stb_d = c_stb_q && !feeder_if.output_c_ack;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            c_q          <= '0;
            acc_q        <= '0;
            result_q     <= '0;
            last_q       <= 1'b0;
            a_stb_q      <= 1'b0;
            b_stb_q      <= 1'b0;
            c_stb_q      <= 1'b0;
            z_ack_q      <= 1'b0;
            result_stb_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rd_en) begin
                        a_q     <= head.a;
                        b_q     <= head.b;
                        c_q     <= acc_q;
                        last_q  <= head.last;
                        a_stb_q <= 1'b1;
                        b_stb_q <= 1'b1;
                        c_stb_q <= 1'b1;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    a_stb_q <= a_stb_d;
                    b_stb_q <= b_stb_d;
                    c_stb_q <= c_stb_d;
                    if (!a_stb_d && !b_stb_d && !c_stb_d) begin
                        z_ack_q <= 1'b1;
                        state_q <= WAIT_Z;
                    end
                end
                WAIT_Z: begin
                    if (z_ack_q && feeder_if.mac_z_stb) begin
                        z_ack_q <= 1'b0;
                        if (last_q) begin
                            result_q     <= feeder_if.mac_z;
                            result_stb_q <= 1'b1;
                            acc_q        <= '0;
                            state_q      <= RESULT;
                        end else begin
                            acc_q   <= feeder_if.mac_z;
                            state_q <= IDLE;
                        end
                    end
                end
                RESULT: begin
                    if (result_stb_q && feeder_if.result_z_ack) begin
                        result_stb_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign feeder_if.output_a     = a_q;
    assign feeder_if.output_a_stb = a_stb_q;
    assign feeder_if.output_b     = b_q;
    assign feeder_if.output_b_stb = b_stb_q;
    assign feeder_if.output_c     = c_q;
    assign feeder_if.output_c_stb = c_stb_q;
    assign feeder_if.mac_z_ack    = z_ack_q;
    assign feeder_if.result_z     = result_q;
    assign feeder_if.result_z_stb = result_stb_q;
    assign feeder_if.fifo_level   = level_q;

endmodule
